// File: rtl/serializador_paralelo.sv
// ---------------------------------------------------------------------------
// serializador_paralelo
//
// Parallel-in / serial-out transmitter. A WIDTH-bit word is taken through a
// valid/ready handshake and shifted out LSB first, one bit per cycle in which
// Shift_en is high. Serial_out feeds the Shift_in of the matching serial-in
// shift-register receiver directly.
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   Reset       synchronous, active-high; overrides every other input
//   Data_in     parallel word, sampled only when a word is accepted
//   Load_valid  source presents a word on Data_in
//   Load_ready  block can accept a word this cycle
//   Shift_en    pacing strobe; a bit advances only while it is 1
//   Serial_out  current serial bit, 0 outside a frame
//   Frame       high while Serial_out carries a valid data bit
//   Done        one-cycle pulse after the last bit of a word is consumed
// ---------------------------------------------------------------------------
module serializador_paralelo #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load_valid,
  output logic             Load_ready,
  input  logic             Shift_en,
  output logic             Serial_out,
  output logic             Frame,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;
  logic             last_s;
  logic             accept_s;

  // Final bit of the word is being consumed on this edge.
  assign last_s   = (state_r == SHIFT) && (cnt_r == LAST_C) && Shift_en;
  assign accept_s = Load_valid && Load_ready;

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a reload on the last bit keeps the frame going.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (Load_valid) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          if (Load_valid) begin
            state_nxt_s = SHIFT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode: Frame and Serial_out come from registered state only;
  // Load_ready also looks at Shift_en so a new word can follow the last bit.
  always_comb begin
    Load_ready = 1'b0;
    Frame      = 1'b0;
    Serial_out = 1'b0;
    case (state_r)
      IDLE: begin
        Load_ready = 1'b1;
        Frame      = 1'b0;
        Serial_out = 1'b0;
      end
      SHIFT: begin
        Load_ready = (cnt_r == LAST_C) && Shift_en;
        Frame      = 1'b1;
        Serial_out = shreg_r[0];
      end
      default: begin
        Load_ready = 1'b0;
        Frame      = 1'b0;
        Serial_out = 1'b0;
      end
    endcase
  end

  // Shift register and bit counter; a load takes priority over a shift.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (accept_s) begin
      shreg_r <= Data_in;
      cnt_r   <= '0;
    end else if ((state_r == SHIFT) && Shift_en && (cnt_r != LAST_C)) begin
      shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  // Completion pulse, one cycle after the last bit is consumed.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= last_s;
    end
  end

  assign Done = done_r;

endmodule

// File: tb/tb_serializador_paralelo.sv
// ---------------------------------------------------------------------------
// Bench for serializador_paralelo (WIDTH=4). The reference model keeps a queue
// of bits still to be transmitted: a frame is "queue not empty", the serial
// bit is the queue head, and Done follows the cycle that pops the last bit.
// A small receiver shift register listens to Serial_out and must hold the
// completed word whenever Done is high.
// ---------------------------------------------------------------------------
module tb_serializador_paralelo;

  localparam int W = 4;

  logic         CLK;
  logic         Reset;
  logic [W-1:0] Data_in;
  logic         Load_valid;
  logic         Load_ready;
  logic         Shift_en;
  logic         Serial_out;
  logic         Frame;
  logic         Done;

  int n_assert;
  int n_fail;

  // Reference model state
  logic         bq[$];
  logic [W-1:0] wq[$];
  logic         exp_done;
  logic [W-1:0] done_word;
  logic [W-1:0] rx;

  serializador_paralelo #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Data_in   (Data_in),
    .Load_valid(Load_valid),
    .Load_ready(Load_ready),
    .Shift_en  (Shift_en),
    .Serial_out(Serial_out),
    .Frame     (Frame),
    .Done      (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock cycle with the inputs currently driven: check, then advance model.
  task automatic tick(input string tag);
    logic exp_frame, exp_so, exp_ready, accept, so_obs;
    #1;
    exp_frame = (bq.size() > 0);
    exp_so    = exp_frame ? bq[0] : 1'b0;
    exp_ready = (bq.size() == 0) || ((bq.size() == 1) && Shift_en);
    so_obs    = Serial_out;

    n_assert++;
    assert (Load_ready === exp_ready) else begin
      n_fail++;
      $error("FAIL %s ready: observed %b expected %b", tag, Load_ready, exp_ready);
    end
    n_assert++;
    assert (Frame === exp_frame) else begin
      n_fail++;
      $error("FAIL %s frame: observed %b expected %b", tag, Frame, exp_frame);
    end
    n_assert++;
    assert (Serial_out === exp_so) else begin
      n_fail++;
      $error("FAIL %s serial: observed %b expected %b", tag, Serial_out, exp_so);
    end
    n_assert++;
    assert (Done === exp_done) else begin
      n_fail++;
      $error("FAIL %s done: observed %b expected %b", tag, Done, exp_done);
    end
    if (exp_done) begin
      n_assert++;
      assert (rx === done_word) else begin
        n_fail++;
        $error("FAIL %s rxword: observed %b expected %b", tag, rx, done_word);
      end
    end

    @(posedge CLK);
    if (Reset) begin
      bq.delete();
      wq.delete();
      exp_done = 1'b0;
    end else begin
      accept   = Load_valid && exp_ready;
      exp_done = (bq.size() == 1) && Shift_en;
      if (exp_frame && Shift_en) rx = {so_obs, rx[W-1:1]};
      if (exp_done) done_word = wq.pop_front();
      if (Shift_en && (bq.size() > 0)) void'(bq.pop_front());
      if (accept) begin
        for (int i = 0; i < W; i++) bq.push_back(Data_in[i]);
        wq.push_back(Data_in);
      end
    end
    #1;
  endtask

  task automatic drive(input logic rst, input logic lv, input logic se,
                       input logic [W-1:0] d, input string tag);
    Reset      = rst;
    Load_valid = lv;
    Shift_en   = se;
    Data_in    = d;
    tick(tag);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    exp_done   = 1'b0;
    done_word  = '0;
    rx         = '0;
    Reset      = 1'b1;
    Load_valid = 1'b0;
    Shift_en   = 1'b0;
    Data_in    = 4'b0000;

    // Reset for two cycles (outputs before the first edge are not checked)
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 1'b0, 4'b0000, "reset");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000, "idle");

    // Single word
    drive(1'b0, 1'b1, 1'b1, 4'b1011, "single_acc");
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000, "single");

    // Back-to-back words, Load_valid held high
    drive(1'b0, 1'b1, 1'b1, 4'b1011, "b2b_acc");
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 4'b0110, "b2b_w1");
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000, "b2b_w2");

    // Pacing: Shift_en low in the 2nd and 3rd frame cycles
    drive(1'b0, 1'b1, 1'b0, 4'b1001, "pace_acc");
    drive(1'b0, 1'b0, 1'b1, 4'b0000, "pace");
    drive(1'b0, 1'b0, 1'b0, 4'b0000, "pace_hold");
    drive(1'b0, 1'b0, 1'b0, 4'b0000, "pace_hold");
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000, "pace");

    // Mid-frame load attempt must be ignored
    drive(1'b0, 1'b1, 1'b1, 4'b0000, "prot_acc");
    drive(1'b0, 1'b0, 1'b1, 4'b0000, "prot_b0");
    drive(1'b0, 1'b1, 1'b1, 4'b1111, "prot_b1");
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000, "prot");

    // Reset at bit 2 of a frame aborts it without Done
    drive(1'b0, 1'b1, 1'b1, 4'b0101, "abort_acc");
    drive(1'b0, 1'b0, 1'b1, 4'b0000, "abort_b0");
    drive(1'b0, 1'b0, 1'b1, 4'b0000, "abort_b1");
    drive(1'b1, 1'b1, 1'b1, 4'b1111, "abort_rst");
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000, "abort_after");

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) != 0), W'($urandom), "rand");
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
